// File: rtl/stopwatch_display_scan_pkg.sv
// Shared constants and types for the stopwatch 4-digit display scanner.
package stopwatch_display_scan_pkg;

  localparam int unsigned DIGIT_COUNT = 4;
  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned IDX_W       = $clog2(DIGIT_COUNT);
  localparam int unsigned SEG_W       = 7;

  // Active-low {g,f,e,d,c,b,a} patterns for a common-anode display
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Element [0] is the rightmost digit
  typedef logic [DIGIT_COUNT-1:0][DIGIT_W-1:0] digits_t;

  typedef enum logic {GAP, SHOW} slot_state_e;

endpackage

// File: rtl/stopwatch_display_scan_if.sv
// Digit input bus and multiplexed display pins of the scanner.
interface stopwatch_display_scan_if;
  import stopwatch_display_scan_pkg::*;

  digits_t              digits_bcd;
  logic                 lz_blank_en;
  logic                 freeze;
  logic [SEG_W-1:0]     seg_n;
  logic                 dp_n;
  logic [DIGIT_COUNT-1:0] an_n;

  modport master (
    output digits_bcd, lz_blank_en, freeze,
    input  seg_n, dp_n, an_n
  );

  modport slave (
    input  digits_bcd, lz_blank_en, freeze,
    output seg_n, dp_n, an_n
  );

endinterface

// File: rtl/stopwatch_display_scan_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 show a dash.
module stopwatch_display_scan_bcd_to_seg7
  import stopwatch_display_scan_pkg::*;
(
  input  logic [DIGIT_W-1:0] code,
  output logic [SEG_W-1:0]   seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (code)
      4'd0: seg_c = SEG_0;
      4'd1: seg_c = SEG_1;
      4'd2: seg_c = SEG_2;
      4'd3: seg_c = SEG_3;
      4'd4: seg_c = SEG_4;
      4'd5: seg_c = SEG_5;
      4'd6: seg_c = SEG_6;
      4'd7: seg_c = SEG_7;
      4'd8: seg_c = SEG_8;
      4'd9: seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_display_scan.sv
// Multiplexed 4-digit 7-segment scanner with anti-ghosting gap, per-frame
// snapshot, leading-zero blanking and a fixed decimal point.
module stopwatch_display_scan
  import stopwatch_display_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 10000,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned DP_POS     = 2,
  parameter int unsigned CNT_W      = 14
) (
  input  logic                    clk,
  input  logic                    reset_n,
  stopwatch_display_scan_if.slave disp
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GAP   = CNT_W'(GAP_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGIT_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_DP    = IDX_W'(DP_POS);
  localparam logic [IDX_W-1:0] IDX_D3    = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_D2    = IDX_W'(2);
  localparam slot_state_e      STATE_RST = (GAP_CYCLES > 0) ? GAP : SHOW;

  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_next;
  logic [IDX_W-1:0]       index;
  digits_t                snapshot;
  slot_state_e            state;
  slot_state_e            state_next;
  logic                   slot_end;
  logic [SEG_W-1:0]       seg_raw;
  logic [SEG_W-1:0]       seg_next;
  logic [SEG_W-1:0]       seg_q;
  logic [DIGIT_COUNT-1:0] an_next;
  logic [DIGIT_COUNT-1:0] an_q;
  logic                   dp_next;
  logic                   dp_q;
  logic                   lead3;
  logic                   lead2;
  logic                   blank;

  assign slot_end   = (count == CNT_LAST);
  assign count_next = slot_end ? '0 : count + CNT_W'(1);

  // Prescaler, digit index and frame snapshot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      index    <= '0;
      snapshot <= '0;
    end else begin
      count <= count_next;
      if (slot_end) begin
        index <= (index == IDX_LAST) ? '0 : index + IDX_W'(1);
        if (index == IDX_LAST && !disp.freeze) begin
          snapshot <= disp.digits_bcd;
        end
      end
    end
  end

  stopwatch_display_scan_bcd_to_seg7 u_dec (
    .code  (snapshot[index]),
    .seg_c (seg_raw)
  );

  // Blanking follows lz_blank_en live while the digits come from the snapshot
  assign lead3 = disp.lz_blank_en && (snapshot[3] == '0);
  assign lead2 = lead3 && (snapshot[2] == '0);
  assign blank = ((index == IDX_D3) && lead3) || ((index == IDX_D2) && lead2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= STATE_RST;
    end else begin
      state <= state_next;
    end
  end

  // Slot state tracks the prescaler; outputs are precomputed for registering
  always_comb begin
    state_next = state;
    an_next    = '1;
    seg_next   = SEG_BLANK;
    dp_next    = 1'b1;
    state_next = (count_next < CNT_GAP) ? GAP : SHOW;
    if (state == SHOW) begin
      an_next[index] = 1'b0;
      seg_next       = blank ? SEG_BLANK : seg_raw;
      dp_next        = (index != IDX_DP);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_next;
      seg_q <= seg_next;
      dp_q  <= dp_next;
    end
  end

  assign disp.an_n  = an_q;
  assign disp.seg_n = seg_q;
  assign disp.dp_n  = dp_q;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Bench for the display scanner: time-based reference model checked every
// cycle, plus directed literal checks at chosen frame/slot/cycle points.
module tb_stopwatch_display_scan;
  import stopwatch_display_scan_pkg::*;

  localparam int unsigned SCAN_DIV   = 8;
  localparam int unsigned GAP_CYCLES = 2;
  localparam int unsigned DP_POS     = 2;
  localparam int unsigned FRAME      = SCAN_DIV * 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic chk_en  = 1'b0;

  int total = 0;
  int bad   = 0;

  // Reference model state: edges since reset release and displayed digits
  int          k       = 0;
  logic [15:0] m_snap  = '0;
  logic [3:0]  exp_an  = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp  = 1'b1;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  stopwatch_display_scan_if disp();

  stopwatch_display_scan #(
    .SCAN_DIV   (SCAN_DIV),
    .GAP_CYCLES (GAP_CYCLES),
    .DP_POS     (DP_POS),
    .CNT_W      (14)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .disp    (disp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask

  // Output registered at time t, from slot position and the frame's digits
  function automatic void model_out(input int t);
    int         c     = t % SCAN_DIV;
    int         idx   = (t / SCAN_DIV) % 4;
    logic [3:0] d     = m_snap[idx*4 +: 4];
    bit         lead3 = disp.lz_blank_en && (m_snap[15:12] == 4'h0);
    bit         lead2 = lead3 && (m_snap[11:8] == 4'h0);
    if (c < GAP_CYCLES) begin
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
    end else begin
      exp_an  = ~(4'b0001 << idx);
      exp_seg = ((idx == 3 && lead3) || (idx == 2 && lead2)) ? 7'h7F : seg_tab[d];
      exp_dp  = (idx == DP_POS) ? 1'b0 : 1'b1;
    end
  endfunction

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      k       = 0;
      m_snap  = '0;
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
    end else begin
      model_out(k);
      if ((k % FRAME) == FRAME - 1 && !disp.freeze) m_snap = disp.digits_bcd;
      k++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("cyc_an_n", 32'(disp.an_n), 32'(exp_an));
      chk("cyc_seg_n", 32'(disp.seg_n), 32'(exp_seg));
      chk("cyc_dp_n", 32'(disp.dp_n), 32'(exp_dp));
      total++;
      if ($countones(~disp.an_n) > 1) begin
        bad++;
        $display("FAIL an_onehot: got %b want at most one low at %0t", disp.an_n, $time);
      end
    end
  end

  // Wait until the outputs reflect the given frame/slot/cycle since reset release
  task automatic at_slot(input int frame, input int slot, input int c);
    int target = frame * FRAME + slot * SCAN_DIV + c + 1;
    int n      = 0;
    while (k != target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (k != target) begin
      total++;
      bad++;
      $display("FAIL wait_slot: got k=%0d want k=%0d", k, target);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    disp.digits_bcd  = 16'h1234;
    disp.lz_blank_en = 1'b0;
    disp.freeze      = 1'b0;
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_an_n", 32'(disp.an_n), 32'h0F);
    chk("rst_seg_n", 32'(disp.seg_n), 32'h7F);
    chk("rst_dp_n", 32'(disp.dp_n), 32'h1);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // First frame shows the zero snapshot
    at_slot(0, 0, 0); chk("f0_gap_an", 32'(disp.an_n), 32'h0F);
    at_slot(0, 0, 2); chk("f0_s0_an", 32'(disp.an_n), 32'h0E);
    chk("f0_s0_seg", 32'(disp.seg_n), 32'h40);
    at_slot(0, 2, 2); chk("f0_s2_dp", 32'(disp.dp_n), 32'h0);

    // Second frame shows 1234
    at_slot(1, 0, 1); chk("f1_gap_an", 32'(disp.an_n), 32'h0F);
    at_slot(1, 0, 2); chk("f1_s0_an", 32'(disp.an_n), 32'h0E);
    chk("f1_s0_seg", 32'(disp.seg_n), 32'h19);
    at_slot(1, 1, 4); chk("f1_s1_dp", 32'(disp.dp_n), 32'h1);
    at_slot(1, 2, 4); chk("f1_s2_dp", 32'(disp.dp_n), 32'h0);
    at_slot(1, 3, 5); chk("f1_s3_an", 32'(disp.an_n), 32'h07);
    chk("f1_s3_seg", 32'(disp.seg_n), 32'h79);
    disp.digits_bcd  = 16'h0005;
    disp.lz_blank_en = 1'b1;

    // 0005 with blanking on, then off (live)
    at_slot(2, 0, 3); chk("f2_s0_seg", 32'(disp.seg_n), 32'h12);
    at_slot(2, 1, 3); chk("f2_s1_seg", 32'(disp.seg_n), 32'h40);
    at_slot(2, 2, 3); chk("f2_s2_seg", 32'(disp.seg_n), 32'h7F);
    chk("f2_s2_dp", 32'(disp.dp_n), 32'h0);
    at_slot(2, 3, 3); chk("f2_s3_seg", 32'(disp.seg_n), 32'h7F);
    chk("f2_s3_an", 32'(disp.an_n), 32'h07);
    disp.lz_blank_en = 1'b0;
    at_slot(3, 2, 3); chk("f3_s2_seg", 32'(disp.seg_n), 32'h40);
    at_slot(3, 3, 3); chk("f3_s3_seg", 32'(disp.seg_n), 32'h40);
    disp.digits_bcd  = 16'h00A0;
    disp.lz_blank_en = 1'b1;

    // Invalid code shows dash; leading zeros blanked
    at_slot(4, 0, 3); chk("f4_s0_seg", 32'(disp.seg_n), 32'h40);
    at_slot(4, 1, 3); chk("f4_s1_seg", 32'(disp.seg_n), 32'h3F);
    at_slot(4, 2, 3); chk("f4_s2_seg", 32'(disp.seg_n), 32'h7F);
    at_slot(4, 3, 3); chk("f4_s3_seg", 32'(disp.seg_n), 32'h7F);
    disp.digits_bcd  = 16'h1234;
    disp.lz_blank_en = 1'b0;

    // Freeze mid-frame holds 1234 while the input moves to 5678
    at_slot(5, 1, 3); disp.freeze = 1'b1;
    at_slot(5, 2, 3); disp.digits_bcd = 16'h5678;
    at_slot(6, 0, 3); chk("f6_s0_seg", 32'(disp.seg_n), 32'h19);
    at_slot(6, 3, 3); chk("f6_s3_seg", 32'(disp.seg_n), 32'h79);
    at_slot(7, 1, 3); chk("f7_s1_seg", 32'(disp.seg_n), 32'h30);
    disp.freeze = 1'b0;
    at_slot(8, 0, 3); chk("f8_s0_seg", 32'(disp.seg_n), 32'h00);
    at_slot(8, 2, 4); chk("f8_s2_seg", 32'(disp.seg_n), 32'h02);

    // Asynchronous reset during SHOW of slot 2
    #2 reset_n = 1'b0;
    #1;
    chk("arst_an_n", 32'(disp.an_n), 32'h0F);
    chk("arst_seg_n", 32'(disp.seg_n), 32'h7F);
    chk("arst_dp_n", 32'(disp.dp_n), 32'h1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    at_slot(0, 0, 0); chk("rel_gap0_an", 32'(disp.an_n), 32'h0F);
    at_slot(0, 0, 1); chk("rel_gap1_an", 32'(disp.an_n), 32'h0F);
    chk("rel_gap1_seg", 32'(disp.seg_n), 32'h7F);
    at_slot(0, 0, 2); chk("rel_s0_an", 32'(disp.an_n), 32'h0E);
    chk("rel_s0_seg", 32'(disp.seg_n), 32'h40);

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
